// File: rtl/l2_cache_if.sv
// L1/memory-facing signal bundle of the L2 cache. The cache uses the slave view;
// the L1 model and the memory model together use the master view.
//
// Handshakes: read_L1_L2/write_L1_L2 are levels held by L1 until the one-cycle
// ready_L2_L1 strobe. read_L2_MEM/write_L2_MEM are held with stable tag, index and
// data until memory answers with a one-cycle ready_MEM_L2 pulse.
interface l2_cache_if #(
    parameter int TNUM_2 = 18,
    parameter int INUM_2 = 8,
    parameter int LINE   = 512
);
    logic [TNUM_2-1:0] tag_L1_L2;
    logic [INUM_2-1:0] index_L1_L2;
    logic [LINE-1:0]   write_data;
    logic [LINE-1:0]   read_data_MEM_L2;
    logic              read_L1_L2;
    logic              write_L1_L2;
    logic              flush;
    logic              ready_MEM_L2;
    logic              ready_L2_L1;
    logic              read_L2_MEM;
    logic              write_L2_MEM;
    logic [INUM_2-1:0] index_L2_MEM;
    logic [TNUM_2-1:0] tag_L2_MEM;
    logic [INUM_2-1:0] write_index_L2_MEM;
    logic [TNUM_2-1:0] write_tag_L2_MEM;
    logic [LINE-1:0]   read_data_L2_L1;
    logic [LINE-1:0]   write_data_L2_MEM;

    modport slave (
        input  tag_L1_L2, index_L1_L2, write_data, read_data_MEM_L2,
               read_L1_L2, write_L1_L2, flush, ready_MEM_L2,
        output ready_L2_L1, read_L2_MEM, write_L2_MEM, index_L2_MEM, tag_L2_MEM,
               write_index_L2_MEM, write_tag_L2_MEM, read_data_L2_L1, write_data_L2_MEM
    );

    modport master (
        output tag_L1_L2, index_L1_L2, write_data, read_data_MEM_L2,
               read_L1_L2, write_L1_L2, flush, ready_MEM_L2,
        input  ready_L2_L1, read_L2_MEM, write_L2_MEM, index_L2_MEM, tag_L2_MEM,
               write_index_L2_MEM, write_tag_L2_MEM, read_data_L2_L1, write_data_L2_MEM
    );
endinterface

// File: rtl/l2_cache.sv
// 4-way set-associative write-back/write-allocate L2 cache with true-LRU replacement.
// Full-line requests from L1; line fills and dirty-victim write-backs to memory.
module l2_cache #(
    parameter int TNUM_2 = 18,
    parameter int INUM_2 = 8,
    parameter int WAYS   = 4,
    parameter int LINE   = 512
) (
    input  logic       clk,
    input  logic       nrst,
    l2_cache_if.slave  bus,
    output logic [2:0] dbg_state
);
    localparam int SETS  = 1 << INUM_2;
    localparam int WBITS = $clog2(WAYS);
    localparam int LBITS = WAYS * WBITS;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH} state_t;

    state_t            state;
    logic [TNUM_2-1:0] tag_mem  [SETS][WAYS];
    logic [LINE-1:0]   data_mem [SETS][WAYS];
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   dirty_q  [SETS];
    logic [LBITS-1:0]  lru_q    [SETS];

    logic [TNUM_2-1:0] req_tag;
    logic [INUM_2-1:0] req_index;
    logic              req_write;
    logic [LINE-1:0]   req_wdata;
    logic [WBITS-1:0]  vic_q;

    logic [WAYS-1:0]   hit_vec;
    logic              hit;
    logic [WBITS-1:0]  hit_way;
    logic [WBITS-1:0]  victim_way;

    // Each way holds an age: 0 = MRU, WAYS-1 = LRU. Ages always form a permutation.
    function automatic logic [LBITS-1:0] lru_reset();
        logic [LBITS-1:0] r;
        r = '0;
        for (int w = 0; w < WAYS; w++) r[w*WBITS +: WBITS] = WBITS'(WAYS - 1 - w);
        return r;
    endfunction

    function automatic logic [LBITS-1:0] lru_touch(input logic [LBITS-1:0] ages,
                                                   input logic [WBITS-1:0] way);
        logic [LBITS-1:0] r;
        logic [WBITS-1:0] a_way;
        r     = ages;
        a_way = ages[int'(way)*WBITS +: WBITS];
        for (int w = 0; w < WAYS; w++) begin
            if (w == int'(way))
                r[w*WBITS +: WBITS] = '0;
            else if (ages[w*WBITS +: WBITS] < a_way)
                r[w*WBITS +: WBITS] = ages[w*WBITS +: WBITS] + WBITS'(1);
        end
        return r;
    endfunction

    always_comb begin
        hit_vec    = '0;
        hit_way    = '0;
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[req_index][w] && (tag_mem[req_index][w] == req_tag);
            if (hit_vec[w]) hit_way = WBITS'(w);
            if (lru_q[req_index][w*WBITS +: WBITS] == WBITS'(WAYS - 1)) victim_way = WBITS'(w);
        end
        // Descending scan so the lowest-numbered invalid way overrides the LRU choice.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_index][w]) victim_way = WBITS'(w);
        end
    end

    assign hit       = |hit_vec;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state                  <= IDLE;
            req_tag                <= '0;
            req_index              <= '0;
            req_write              <= 1'b0;
            req_wdata              <= '0;
            vic_q                  <= '0;
            bus.ready_L2_L1        <= 1'b0;
            bus.read_L2_MEM        <= 1'b0;
            bus.write_L2_MEM       <= 1'b0;
            bus.index_L2_MEM       <= '0;
            bus.tag_L2_MEM         <= '0;
            bus.write_index_L2_MEM <= '0;
            bus.write_tag_L2_MEM   <= '0;
            bus.read_data_L2_L1    <= '0;
            bus.write_data_L2_MEM  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                lru_q[s]   <= lru_reset();
            end
        end else begin
            bus.ready_L2_L1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        state <= FLUSH;
                    end else if (bus.read_L1_L2 || bus.write_L1_L2) begin
                        req_tag   <= bus.tag_L1_L2;
                        req_index <= bus.index_L1_L2;
                        req_write <= bus.write_L1_L2;
                        req_wdata <= bus.write_data;
                        state     <= COMPARE;
                    end
                end
                FLUSH: begin
                    for (int s = 0; s < SETS; s++) begin
                        valid_q[s] <= '0;
                        dirty_q[s] <= '0;
                        lru_q[s]   <= lru_reset();
                    end
                    state <= IDLE;
                end
                COMPARE: begin
                    if (hit) begin
                        bus.ready_L2_L1  <= 1'b1;
                        lru_q[req_index] <= lru_touch(lru_q[req_index], hit_way);
                        if (req_write)
                            dirty_q[req_index][hit_way] <= 1'b1;
                        else
                            bus.read_data_L2_L1 <= data_mem[req_index][hit_way];
                        state <= IDLE;
                    end else begin
                        vic_q <= victim_way;
                        if (valid_q[req_index][victim_way] && dirty_q[req_index][victim_way]) begin
                            bus.write_L2_MEM       <= 1'b1;
                            bus.write_tag_L2_MEM   <= tag_mem[req_index][victim_way];
                            bus.write_index_L2_MEM <= req_index;
                            bus.write_data_L2_MEM  <= data_mem[req_index][victim_way];
                            state                  <= WRITE_BACK;
                        end else begin
                            bus.read_L2_MEM  <= 1'b1;
                            bus.tag_L2_MEM   <= req_tag;
                            bus.index_L2_MEM <= req_index;
                            state            <= ALLOCATE;
                        end
                    end
                end
                WRITE_BACK: begin
                    if (bus.ready_MEM_L2) begin
                        dirty_q[req_index][vic_q] <= 1'b0;
                        bus.write_L2_MEM          <= 1'b0;
                        bus.read_L2_MEM           <= 1'b1;
                        bus.tag_L2_MEM            <= req_tag;
                        bus.index_L2_MEM          <= req_index;
                        state                     <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (bus.ready_MEM_L2) begin
                        valid_q[req_index][vic_q] <= 1'b1;
                        dirty_q[req_index][vic_q] <= 1'b0;
                        lru_q[req_index]          <= lru_touch(lru_q[req_index], vic_q);
                        bus.read_L2_MEM           <= 1'b0;
                        state                     <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; validity alone decides whether contents matter.
    always_ff @(posedge clk) begin
        if (nrst) begin
            if (state == ALLOCATE && bus.ready_MEM_L2) begin
                data_mem[req_index][vic_q] <= bus.read_data_MEM_L2;
                tag_mem[req_index][vic_q]  <= req_tag;
            end else if (state == COMPARE && hit && req_write) begin
                data_mem[req_index][hit_way] <= req_wdata;
            end
        end
    end
endmodule

// File: tb/tb_l2_cache.sv
// Directed bench for l2_cache: L1 driver, reactive memory model and a read-data
// scoreboard queue, with immediate assertions at every comparison point.
`timescale 1ns/1ps
module tb_l2_cache;
    localparam int T = 18;
    localparam int I = 8;
    localparam int L = 512;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [2:0] dbg_state;

    l2_cache_if bus();

    l2_cache dut (
        .clk       (clk),
        .nrst      (nrst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [L-1:0]  exp_q[$];
    logic [L-1:0]  wline [4];
    logic [T-1:0]  tg [8];

    task automatic check(input string name, input logic [L-1:0] obs, input logic [L-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [L-1:0] fv(input logic [T-1:0] t, input logic [I-1:0] i);
        logic [L-1:0] r;
        for (int k = 0; k < 16; k++)
            r[k*32 +: 32] = {t[13:0], i, 5'(k), 5'h15} ^ 32'(32'h9e3779b9 * (k + 1));
        return r;
    endfunction

    task automatic mem_respond(input logic [L-1:0] data);
        int lat;
        lat = $urandom_range(0, 3);
        repeat (lat) begin
            @(posedge clk);
            #1;
        end
        bus.ready_MEM_L2     = 1'b1;
        bus.read_data_MEM_L2 = data;
        @(posedge clk);
        #1;
        bus.ready_MEM_L2     = 1'b0;
        bus.read_data_MEM_L2 = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"},  L'(bus.ready_L2_L1), '0);
        check({tag, "_rd_mem"}, L'(bus.read_L2_MEM), '0);
        check({tag, "_wr_mem"}, L'(bus.write_L2_MEM), '0);
        check({tag, "_idx"},    L'(bus.index_L2_MEM), '0);
        check({tag, "_tag"},    L'(bus.tag_L2_MEM), '0);
        check({tag, "_widx"},   L'(bus.write_index_L2_MEM), '0);
        check({tag, "_wtag"},   L'(bus.write_tag_L2_MEM), '0);
        check({tag, "_rdata"},  bus.read_data_L2_L1, '0);
        check({tag, "_wdata"},  bus.write_data_L2_MEM, '0);
        check({tag, "_state"},  L'(dbg_state), '0);
    endtask

    // One L1 transaction, serving memory requests until the ready strobe.
    task automatic access(input bit wr, input logic [T-1:0] tag, input logic [I-1:0] idx,
                          input logic [L-1:0] wdata, input bit exp_miss, input bit exp_wb,
                          input logic [T-1:0] wb_tag, input logic [L-1:0] wb_data,
                          input logic [L-1:0] exp_rd, input bit with_flush);
        int           cyc;
        int           n_wb;
        int           n_fill;
        bit           done;
        bit           both_seen;
        logic [L-1:0] e;
        if (!wr) exp_q.push_back(exp_rd);
        bus.tag_L1_L2   = tag;
        bus.index_L1_L2 = idx;
        bus.write_data  = wdata;
        bus.write_L1_L2 = wr;
        bus.read_L1_L2  = !wr;
        bus.flush       = with_flush;
        cyc = 0; n_wb = 0; n_fill = 0; done = 0; both_seen = 0;
        while (!done && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.flush = 1'b0;
            if (bus.read_L2_MEM && bus.write_L2_MEM) both_seen = 1;
            if (bus.ready_L2_L1) begin
                done            = 1;
                bus.read_L1_L2  = 1'b0;
                bus.write_L1_L2 = 1'b0;
                if (!exp_miss) check("hit_latency", L'(cyc), L'(2));
                if (!wr && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("read_data", bus.read_data_L2_L1, e);
                end
            end else if (bus.write_L2_MEM) begin
                n_wb++;
                check("wb_tag",   L'(bus.write_tag_L2_MEM), L'(wb_tag));
                check("wb_index", L'(bus.write_index_L2_MEM), L'(idx));
                check("wb_data",  bus.write_data_L2_MEM, wb_data);
                mem_respond('0);
            end else if (bus.read_L2_MEM) begin
                n_fill++;
                check("fill_tag",   L'(bus.tag_L2_MEM), L'(tag));
                check("fill_index", L'(bus.index_L2_MEM), L'(idx));
                mem_respond(fv(tag, idx));
            end
        end
        check("completed", L'(done), L'(1));
        check("mem_exclusive", L'(both_seen), L'(0));
        check("wb_count", L'(n_wb), L'(exp_wb));
        check("fill_count", L'(n_fill), L'(exp_miss));
        if (done) begin
            @(posedge clk);
            #1;
            check("ready_one_cycle", L'(bus.ready_L2_L1), L'(0));
        end else begin
            bus.read_L1_L2  = 1'b0;
            bus.write_L1_L2 = 1'b0;
            exp_q.delete();
        end
    endtask

    initial begin
        int wait_cyc;
        bus.tag_L1_L2        = '0;
        bus.index_L1_L2      = '0;
        bus.write_data       = '0;
        bus.read_data_MEM_L2 = '0;
        bus.read_L1_L2       = 1'b0;
        bus.write_L1_L2      = 1'b0;
        bus.flush            = 1'b0;
        bus.ready_MEM_L2     = 1'b0;
        for (int k = 0; k < 8; k++) tg[k] = 18'h0a5a0 + T'(k * 18'h01111);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 16; j++) wline[k][j*32 +: 32] = $urandom;

        // Clock/reset
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Cold fills: tags A..D fill ways 0..3 of every set, clean
        for (int t = 0; t < 4; t++)
            for (int i = 0; i < 256; i++)
                access(0, tg[t], I'(i), '0, 1, 0, '0, '0, fv(tg[t], I'(i)), 0);

        // Everything resident: all hits with 2-cycle latency
        for (int t = 0; t < 4; t++)
            for (int i = 0; i < 256; i++)
                access(0, tg[t], I'(i), '0, 0, 0, '0, '0, fv(tg[t], I'(i)), 0);

        // New tag E evicts way0 (clean, no write-back)
        for (int i = 0; i < 256; i++)
            access(0, tg[4], I'(i), '0, 1, 0, '0, '0, fv(tg[4], I'(i)), 0);

        // Next new tag F evicts way1 (tag B); C still resident, B now misses
        for (int i = 0; i < 4; i++) begin
            access(0, tg[5], I'(i), '0, 1, 0, '0, '0, fv(tg[5], I'(i)), 0);
            access(0, tg[2], I'(i), '0, 0, 0, '0, '0, fv(tg[2], I'(i)), 0);
            access(0, tg[1], I'(i), '0, 1, 0, '0, '0, fv(tg[1], I'(i)), 0);
        end

        // Flush, then write-allocate a full line and read it back
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(posedge clk);
        #1;
        access(1, tg[0], 8'd0, wline[0], 1, 0, '0, '0, '0, 0);
        access(0, tg[0], 8'd0, '0, 0, 0, '0, '0, wline[0], 0);

        // Dirty all four ways of set 1, then force write-backs of the LRU victims
        for (int t = 0; t < 4; t++)
            access(1, tg[t], 8'd1, wline[t], 1, 0, '0, '0, '0, 0);
        access(0, tg[4], 8'd1, '0, 1, 1, tg[0], wline[0], fv(tg[4], 8'd1), 0);
        access(0, tg[5], 8'd1, '0, 1, 1, tg[1], wline[1], fv(tg[5], 8'd1), 0);
        access(0, tg[1], 8'd1, '0, 1, 1, tg[2], wline[2], fv(tg[1], 8'd1), 0);

        // Flush alongside a read: flush first, dirty A@0 discarded, read misses clean
        access(0, tg[0], 8'd0, '0, 1, 0, '0, '0, fv(tg[0], 8'd0), 1);

        // Reset while waiting in ALLOCATE
        bus.tag_L1_L2   = tg[6];
        bus.index_L1_L2 = 8'd9;
        bus.read_L1_L2  = 1'b1;
        wait_cyc = 0;
        do begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end while (!bus.read_L2_MEM && wait_cyc < 20);
        check("alloc_reached", L'(bus.read_L2_MEM), L'(1));
        nrst           = 1'b0;
        bus.read_L1_L2 = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("mid_reset");
        nrst = 1'b1;
        @(posedge clk);
        #1;
        access(0, tg[0], 8'd0, '0, 1, 0, '0, '0, fv(tg[0], 8'd0), 0);
        access(0, tg[6], 8'd9, '0, 1, 0, '0, '0, fv(tg[6], 8'd9), 0);

        check("scoreboard_drained", L'(exp_q.size()), L'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/l2_cache.md
Name: l2_cache

Overview:
- Unified L2 cache between the L1 and main memory.
- Organisation: 4-way set-associative, 64-byte (512-bit) lines, 256 sets, write-back, write-allocate, true-LRU replacement.
- L1 side: one full-line read or write request at a time via a request/ready handshake.
- Memory side: line fills and dirty-victim write-backs, each completed by a single ready_MEM_L2 pulse.

Parameters:
- TNUM_2, 18, tag width (address bits 31:14).
- INUM_2, 8, index width (address bits 13:6); number of sets = 2^INUM_2.
- WAYS, 4, associativity.
- LINE, 512, line width in bits.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- nrst  in  1  synchronous active-low reset.
- tag_L1_L2  in  TNUM_2  request tag.
- index_L1_L2  in  INUM_2  request set index.
- write_data  in  512  full-line write data from L1.
- read_data_MEM_L2  in  512  fill data from memory; valid when ready_MEM_L2=1.
- read_L1_L2  in  1  read request, level, held until ready_L2_L1.
- write_L1_L2  in  1  write request, level, held until ready_L2_L1.
- flush  in  1  invalidate whole cache.
- ready_MEM_L2  in  1  memory completion pulse for the current read or write.
- ready_L2_L1  out  1  one-cycle completion strobe to L1.
- read_L2_MEM  out  1  line fill request.
- write_L2_MEM  out  1  write-back request.
- index_L2_MEM  out  INUM_2  fill index.
- tag_L2_MEM  out  TNUM_2  fill tag.
- write_index_L2_MEM  out  INUM_2  victim index.
- write_tag_L2_MEM  out  TNUM_2  victim tag.
- read_data_L2_L1  out  512  read data to L1.
- write_data_L2_MEM  out  512  victim line data.

Behaviour:
- Reset (nrst=0 at a clock edge):
  - FSM goes to IDLE.
  - All valid, dirty and LRU state cleared.
  - All outputs 0.
  - Reset mid-transaction abandons the transaction.
- FSM states: IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH.
- IDLE:
  - flush=1: go to FLUSH. Flush has priority over a simultaneous request.
  - Otherwise, if read_L1_L2 or write_L1_L2 is 1: latch tag, index, op and write_data; go to COMPARE.
  - If both read and write are asserted, write wins.
- FLUSH: one cycle. Clears every valid and dirty bit and resets LRU; no write-back is performed (dirty data is discarded). Returns to IDLE. A flush asserted outside IDLE is ignored.
- COMPARE, hit (valid way with matching tag):
  - ready_L2_L1=1 for this cycle only.
  - Read: read_data_L2_L1 is driven with the line and held until the next hit.
  - Write: the whole line is replaced by the latched write_data and dirty is set.
  - The hit way becomes MRU. Next state is IDLE.
  - Hit latency = 2 cycles from the request being sampled in IDLE.
- COMPARE, miss:
  - Victim selection: lowest-numbered invalid way; otherwise the LRU way.
  - Victim valid and dirty: go to WRITE_BACK. Otherwise go to ALLOCATE.
- WRITE_BACK:
  - write_L2_MEM=1; write_tag_L2_MEM and write_index_L2_MEM carry the victim's tag and index; write_data_L2_MEM carries the victim line.
  - Held stable until ready_MEM_L2=1. On that cycle: clear dirty, go to ALLOCATE.
- ALLOCATE:
  - read_L2_MEM=1; tag_L2_MEM and index_L2_MEM carry the request tag and index.
  - Held until ready_MEM_L2=1. On that edge: capture read_data_MEM_L2 into the victim way, set valid, clear dirty, drop read_L2_MEM, return to COMPARE.
  - The retried COMPARE hits. A write then merges (full-line overwrite) and sets dirty.
- Memory-side signal rules:
  - read_L2_MEM and write_L2_MEM are never both 1.
  - ready_MEM_L2 has no effect outside WRITE_BACK and ALLOCATE.
  - Memory latency is unbounded.
- Request sampling: L1 may keep the request asserted after ready. A request still high in IDLE is sampled again; a repeated hit is harmless.
- LRU: per-set full ordering of 4 ways. A hit or a fill makes the accessed way MRU. On an empty set, fill order is way0, 1, 2, 3. The first replacement after that is way0.

Test Plan:
- Reset, then read 256 distinct indices (tag A) -> each read_L2_MEM=1 with the correct tag/index; after ready_MEM_L2, ready_L2_L1 pulses and read_data_L2_L1 equals the supplied fill data. Repeat with tags B, C, D -> ways 1-3 fill; no write_L2_MEM.
- Re-read all 1024 addresses -> every access hits: ready_L2_L1 2 cycles after request, no read_L2_MEM, data matches the original fills.
- Read a new tag E on each set -> way0 (LRU) is replaced with no write-back; the next new tag replaces way1.
- Flush, then write tag A with full line W -> miss fill (read_L2_MEM), then ready_L2_L1; a subsequent read of A returns W.
- With dirty lines in all 4 ways, read a new tag -> WRITE_BACK first: write_L2_MEM=1, write_tag_L2_MEM equals the LRU victim's tag, write_data_L2_MEM=W. Then a fill follows, and L1 gets the new data.
- Assert flush together with read_L1_L2 in IDLE -> flush taken first; the subsequent read misses. Pulse nrst=0 during ALLOCATE -> all outputs 0 next cycle and the cache is empty.
